// File: rtl/cpu_pkg.sv
// Shared definitions for the eight-bit CPU control path: opcodes, sequencer
// states, accumulator source encodings, decoded-instruction and strobe bundles.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

  // Opcodes as seen in IR[7:4]; 9..D are unassigned and behave as NOP
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Accumulator input mux selects
  localparam logic [1:0] ACC_SRC_MEM = 2'd0;
  localparam logic [1:0] ACC_SRC_ALU = 2'd1;
  localparam logic [1:0] ACC_SRC_IMM = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    HALT   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'd0,
    JMP_ALWAYS = 2'd1,
    JMP_CARRY  = 2'd2,
    JMP_ZERO   = 2'd3
  } jump_t;

  // Decoded view of one opcode
  typedef struct packed {
    logic  mem_op;    // needs a MEM cycle (LDA/ADD/SUB/STA)
    logic  is_store;  // STA
    logic  is_sub;    // SUB
    logic  is_alu;    // ADD or SUB
    jump_t jump;
    logic  is_halt;
    logic  is_out;
    logic  is_ldi;
  } dec_t;

  // Datapath strobe bundle driven by the sequencer
  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       mar_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic [1:0] acc_src;
    logic       alu_sub;
    logic       flags_load;
    logic       out_load;
  } ctl_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// Opcode classifier shared by the sequencer and the disassembler monitor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows opcode directly.
// Ports: opcode (IR[7:4]) in, dec (dec_t bundle) out.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec      = '0;
    dec.jump = JMP_NONE;
    case (opcode)
      OP_LDA: dec.mem_op = 1'b1;
      OP_ADD: begin
        dec.mem_op = 1'b1;
        dec.is_alu = 1'b1;
      end
      OP_SUB: begin
        dec.mem_op = 1'b1;
        dec.is_alu = 1'b1;
        dec.is_sub = 1'b1;
      end
      OP_STA: begin
        dec.mem_op   = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_LDI: dec.is_ldi  = 1'b1;
      OP_JMP: dec.jump    = JMP_ALWAYS;
      OP_JC:  dec.jump    = JMP_CARRY;
      OP_JZ:  dec.jump    = JMP_ZERO;
      OP_OUT: dec.is_out  = 1'b1;
      OP_HLT: dec.is_halt = 1'b1;
      default: ;  // NOP and unassigned opcodes
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute control FSM for the eight-bit CPU datapath.
// Latency: 2 cycles per register/jump instruction, 3 per memory instruction, +1 per mem_ready-low cycle.
// Backpressure: mem_ready low stretches FETCH/MEM; WAIT_MAX+1 consecutive low cycles lock into FAULT.
// Ports: clk, reset (async active-low); opcode/flag_z/flag_c/mem_ready in; step in
// only when CPU_SEQ_STEP_EN is defined (single-step gating of FETCH). Outputs are
// Mealy datapath strobes plus registered halted/bus_error status.
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       mem_ready,
`ifdef CPU_SEQ_STEP_EN
  input  logic       step,
`endif
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mar_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_load,
  output logic [1:0] acc_src,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic       bus_error
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       halted_q, bus_error_q;
  logic       fetch_go;
  logic       waiting;
  dec_t       dec;
  ctl_t       ctl, ctl_out;

  cpu_seq_decode u_decode (
    .opcode (opcode),
    .dec    (dec)
  );

`ifdef CPU_SEQ_STEP_EN
  // A step rising edge arms one fetch; the arm is consumed when IR loads.
  // An edge arriving in the same cycle as the consume re-arms for the next one.
  logic step_q, step_armed, step_edge;

  assign step_edge = step & ~step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q     <= 1'b0;
      step_armed <= 1'b0;
    end else begin
      step_q <= step;
      if (step_edge)
        step_armed <= 1'b1;
      else if (state == FETCH && mem_ready)
        step_armed <= 1'b0;
    end
  end

  assign fetch_go = step_armed;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    ctl        = '0;
    state_next = state;
    case (state)
      FETCH: begin
        if (fetch_go) begin
          ctl.mem_rd = 1'b1;
          if (mem_ready) begin
            ctl.ir_load = 1'b1;
            ctl.pc_inc  = 1'b1;
            state_next  = DECODE;
          end else if (wait_cnt == WAIT_LIM) begin
            state_next = FAULT;
          end
        end
      end
      DECODE: begin
        ctl.acc_load = dec.is_ldi;
        ctl.acc_src  = dec.is_ldi ? ACC_SRC_IMM : ACC_SRC_MEM;
        ctl.out_load = dec.is_out;
        case (dec.jump)
          JMP_ALWAYS: ctl.pc_load = 1'b1;
          JMP_CARRY:  ctl.pc_load = flag_c;
          JMP_ZERO:   ctl.pc_load = flag_z;
          default:    ctl.pc_load = 1'b0;
        endcase
        if (dec.mem_op)
          state_next = MEM;
        else if (dec.is_halt)
          state_next = HALT;
        else
          state_next = FETCH;
      end
      MEM: begin
        ctl.mar_sel = 1'b1;
        ctl.mem_wr  = dec.is_store;
        ctl.mem_rd  = ~dec.is_store;
        if (mem_ready) begin
          if (!dec.is_store) begin
            ctl.acc_load = 1'b1;
            if (dec.is_alu) begin
              ctl.acc_src    = ACC_SRC_ALU;
              ctl.flags_load = 1'b1;
              ctl.alu_sub    = dec.is_sub;
            end
          end
          state_next = FETCH;
        end else if (wait_cnt == WAIT_LIM) begin
          state_next = FAULT;
        end
      end
      HALT:    state_next = HALT;
      FAULT:   state_next = FAULT;
      default: state_next = FETCH;
    endcase
  end

  // Only a live memory access counts as waiting; a step hold does not.
  assign waiting = ((state == FETCH && fetch_go) || state == MEM) && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      wait_cnt    <= 4'd0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state       <= state_next;
      halted_q    <= (state_next == HALT);
      bus_error_q <= (state_next == FAULT);
      // Any state change clears, which covers every entry into FETCH or MEM.
      if (state_next != state)
        wait_cnt <= 4'd0;
      else if (waiting)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Strobes are combinational from state, so gate them while reset is held.
  assign ctl_out = reset ? ctl : '0;

  assign pc_inc     = ctl_out.pc_inc;
  assign pc_load    = ctl_out.pc_load;
  assign ir_load    = ctl_out.ir_load;
  assign mar_sel    = ctl_out.mar_sel;
  assign mem_rd     = ctl_out.mem_rd;
  assign mem_wr     = ctl_out.mem_wr;
  assign acc_load   = ctl_out.acc_load;
  assign acc_src    = ctl_out.acc_src;
  assign alu_sub    = ctl_out.alu_sub;
  assign flags_load = ctl_out.flags_load;
  assign out_load   = ctl_out.out_load;
  assign halted     = halted_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: each instruction is expanded
// into its expected per-cycle strobe trace from the instruction-level rules,
// with randomized opcodes, flags and memory wait counts.
module tb_cpu_control_sequencer;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       mar_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic [1:0] acc_src;
    logic       alu_sub;
    logic       flags_load;
    logic       out_load;
    logic       halted;
    logic       bus_error;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_z, flag_c, mem_ready;
`ifdef CPU_SEQ_STEP_EN
  logic       step;
`endif
  logic       pc_inc, pc_load, ir_load, mar_sel, mem_rd, mem_wr, acc_load;
  logic [1:0] acc_src;
  logic       alu_sub, flags_load, out_load, halted, bus_error;

  obs_t obs;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .mem_ready  (mem_ready),
`ifdef CPU_SEQ_STEP_EN
    .step       (step),
`endif
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .ir_load    (ir_load),
    .mar_sel    (mar_sel),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .acc_load   (acc_load),
    .acc_src    (acc_src),
    .alu_sub    (alu_sub),
    .flags_load (flags_load),
    .out_load   (out_load),
    .halted     (halted),
    .bus_error  (bus_error)
  );

  assign obs = {pc_inc, pc_load, ir_load, mar_sel, mem_rd, mem_wr, acc_load,
                acc_src, alu_sub, flags_load, out_load, halted, bus_error};

  task automatic chk(input obs_t exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_ready at negedge, sample 1ns later, advance.
  task automatic cyc(input logic rdy, input obs_t exp, input string tag);
    mem_ready = rdy;
    #1;
    chk(exp, tag);
    @(negedge clk);
  endtask

  task automatic fault_tail();
    obs_t e;
    e = '0;
    e.bus_error = 1'b1;
    repeat (3) cyc(1'($urandom), e, "fault_sticky");
  endtask

  task automatic do_reset();
    obs_t e;
    e = '0;
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 4'($urandom);
    #1;
    chk(e, "reset_async");
    @(negedge clk);
    #1;
    chk(e, "reset_held");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one instruction and checks every cycle of it.
  // ended: 0 normal completion, 1 halted, 2 bus fault.
  task automatic run_instr(input logic [3:0] op, input logic fz, input logic fc,
                           input int wf, input int wm, output int ended);
    obs_t e;
    logic memop;
    opcode = op;
    flag_z = fz;
    flag_c = fc;
    // Fetch: wf wait cycles, then the completing cycle
    e = '0;
    e.mem_rd = 1'b1;
    if (wf > WAIT_MAX) begin
      repeat (WAIT_MAX + 1) cyc(1'b0, e, "fetch_wait_to_fault");
      fault_tail();
      ended = 2;
      return;
    end
    repeat (wf) cyc(1'b0, e, "fetch_wait");
    e.ir_load = 1'b1;
    e.pc_inc  = 1'b1;
    cyc(1'b1, e, "fetch_done");
    // Decode: exactly one cycle, mem_ready ignored
    e = '0;
    memop = (op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'h4);
    case (op)
      4'h5: begin e.acc_load = 1'b1; e.acc_src = 2'd2; end
      4'h6: e.pc_load  = 1'b1;
      4'h7: e.pc_load  = fc;
      4'h8: e.pc_load  = fz;
      4'hE: e.out_load = 1'b1;
      default: ;
    endcase
    cyc(1'($urandom), e, "decode");
    if (op == 4'hF) begin
      e = '0;
      e.halted = 1'b1;
      repeat (3) cyc(1'($urandom), e, "halt");
      ended = 1;
      return;
    end
    if (memop) begin
      e = '0;
      e.mar_sel = 1'b1;
      e.mem_wr  = (op == 4'h4);
      e.mem_rd  = (op != 4'h4);
      if (wm > WAIT_MAX) begin
        repeat (WAIT_MAX + 1) cyc(1'b0, e, "mem_wait_to_fault");
        fault_tail();
        ended = 2;
        return;
      end
      repeat (wm) cyc(1'b0, e, "mem_wait");
      if (op == 4'h1) begin
        e.acc_load = 1'b1;
        e.acc_src  = 2'd0;
      end else if (op == 4'h2 || op == 4'h3) begin
        e.acc_load   = 1'b1;
        e.acc_src    = 2'd1;
        e.flags_load = 1'b1;
        e.alu_sub    = (op == 4'h3);
      end
      cyc(1'b1, e, "mem_done");
    end
    ended = 0;
  endtask

  initial begin
    int ended;
    obs_t e;
    reset     = 1'b0;
    opcode    = 4'h0;
    flag_z    = 1'b0;
    flag_c    = 1'b0;
    mem_ready = 1'b1;
`ifdef CPU_SEQ_STEP_EN
    step      = 1'b0;
`endif
    @(negedge clk);
    do_reset();

`ifndef CPU_SEQ_STEP_EN
    // Directed scenarios
    run_instr(4'h5, 1'b0, 1'b0, 0, 0, ended);   // LDI
    run_instr(4'h2, 1'b0, 1'b0, 0, 3, ended);   // ADD with 3 MEM waits
    run_instr(4'h8, 1'b0, 1'b1, 0, 0, ended);   // JZ not taken
    run_instr(4'h8, 1'b1, 1'b0, 0, 0, ended);   // JZ taken
    run_instr(4'h7, 1'b0, 1'b1, 1, 0, ended);   // JC taken
    run_instr(4'h4, 1'b1, 1'b1, 2, 1, ended);   // STA
    run_instr(4'h3, 1'b0, 1'b0, WAIT_MAX, WAIT_MAX, ended);  // longest legal waits
    run_instr(4'hE, 1'b0, 1'b0, 0, 0, ended);   // OUT
    run_instr(4'hB, 1'b1, 1'b1, 0, 0, ended);   // unassigned -> NOP

    // Randomized instruction stream (no HLT)
    for (int i = 0; i < 80; i++) begin
      run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, ended);
    end

    // HLT is terminal: strobes 0, halted 1 for 20 cycles
    run_instr(4'hF, 1'b0, 1'b0, 0, 0, ended);
    e = '0;
    e.halted = 1'b1;
    for (int i = 0; i < 17; i++) begin
      opcode = 4'($urandom);
      cyc(1'($urandom), e, "halt_hold");
    end
    do_reset();

    // Fetch stall -> fault after 16 cycles, sticky until reset
    run_instr(4'h0, 1'b0, 1'b0, 99, 0, ended);
    do_reset();
    run_instr(4'h0, 1'b0, 1'b0, 0, 0, ended);   // normal operation after reset

    // MEM stall -> fault
    run_instr(4'h1, 1'b0, 1'b0, 0, 99, ended);
    do_reset();

    // Reset mid-instruction: abort during MEM, restart from FETCH
    run_instr(4'h5, 1'b0, 1'b0, 0, 0, ended);
    opcode = 4'h1;
    e = '0; e.mem_rd = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
    cyc(1'b1, e, "abort_fetch");
    e = '0;
    cyc(1'b1, e, "abort_decode");
    do_reset();
    run_instr(4'h6, 1'b0, 1'b0, 0, 0, ended);   // JMP after restart
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
